// File: rtl/neotang_uart_cmd.sv
// Host command parser: decodes UART bytes into joypad, OSD-enable and OSD pixel
// updates, commits them atomically and answers every command with one ack byte.
module neotang_uart_cmd #(
  parameter int OSD_ADDR_W     = 11,
  parameter int OSD_PIXELS     = 2048,
  parameter int TIMEOUT_CYCLES = 2700
) (
  input  logic                  clk_27m,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic [15:0]           joy1,
  output logic [15:0]           joy2,
  output logic                  osd_en,
  output logic                  osd_wr_valid,
  input  logic                  osd_wr_ready,
  output logic [OSD_ADDR_W-1:0] osd_wr_addr,
  output logic [23:0]           osd_wr_data,
  output logic [7:0]            err_count,
  output logic                  busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_OSD_WR, S_ACK} state_t;

  state_t                state_q, state_d;
  logic [7:0]            op_q, op_d, b0_q, b0_d, b1_q, b1_d;
  logic [1:0]            idx_q, idx_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [15:0]           joy1_q, joy1_d, joy2_q, joy2_d;
  logic                  osd_en_q, osd_en_d;
  logic [OSD_ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]           wdata_q, wdata_d;
  logic [7:0]            err_q, err_d, err_sat;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  rx_ready_q, tx_valid_q, osd_wr_valid_q;
  logic                  rx_fire;

  assign rx_fire = rx_valid && rx_ready_q;
  assign err_sat = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    idx_d     = idx_q;
    to_d      = to_q;
    joy1_d    = joy1_q;
    joy2_d    = joy2_q;
    osd_en_d  = osd_en_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        case (rx_data)
          8'h01, 8'h02, 8'h08: begin
            op_d    = rx_data;
            idx_d   = 2'd0;
            to_d    = '0;
            state_d = S_PAYLOAD;
          end
          8'h06: begin
            osd_en_d  = 1'b1;
            tx_data_d = 8'h86;
            state_d   = S_ACK;
          end
          8'h07: begin
            osd_en_d  = 1'b0;
            addr_d    = '0;
            tx_data_d = 8'h87;
            state_d   = S_ACK;
          end
          default: begin
            err_d     = err_sat;
            tx_data_d = 8'hFF;
            state_d   = S_ACK;
          end
        endcase
      end
      S_PAYLOAD: begin
        // An accepted byte takes priority over a timeout on the same cycle.
        if (rx_fire) begin
          to_d  = '0;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd0) b0_d = rx_data;
          if (idx_q == 2'd1) b1_d = rx_data;
          if (op_q != 8'h08 && idx_q == 2'd1) begin
            if (op_q == 8'h01) joy1_d = {rx_data, b0_q};
            else               joy2_d = {rx_data, b0_q};
            tx_data_d = op_q | 8'h80;
            state_d   = S_ACK;
          end else if (op_q == 8'h08 && idx_q == 2'd2) begin
            wdata_d = {b0_q, b1_q, rx_data};
            state_d = S_OSD_WR;
          end
        end else if (to_q == TO_W'(TIMEOUT_CYCLES)) begin
          err_d     = err_sat;
          tx_data_d = 8'hFF;
          state_d   = S_ACK;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_OSD_WR: if (osd_wr_ready) begin
        addr_d    = (addr_q == OSD_ADDR_W'(OSD_PIXELS - 1)) ? '0 : addr_q + 1'b1;
        tx_data_d = op_q | 8'h80;
        state_d   = S_ACK;
      end
      S_ACK: if (tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_27m or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      b0_q           <= '0;
      b1_q           <= '0;
      idx_q          <= '0;
      to_q           <= '0;
      joy1_q         <= 16'hFFFF;
      joy2_q         <= 16'hFFFF;
      osd_en_q       <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      err_q          <= '0;
      tx_data_q      <= '0;
      rx_ready_q     <= 1'b1;
      tx_valid_q     <= 1'b0;
      osd_wr_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      b0_q           <= b0_d;
      b1_q           <= b1_d;
      idx_q          <= idx_d;
      to_q           <= to_d;
      joy1_q         <= joy1_d;
      joy2_q         <= joy2_d;
      osd_en_q       <= osd_en_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      err_q          <= err_d;
      tx_data_q      <= tx_data_d;
      // Handshake strobes are decoded from the next state so they leave a flop.
      rx_ready_q     <= (state_d == S_IDLE) || (state_d == S_PAYLOAD);
      tx_valid_q     <= (state_d == S_ACK);
      osd_wr_valid_q <= (state_d == S_OSD_WR);
    end
  end

  assign rx_ready     = rx_ready_q;
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign joy1         = joy1_q;
  assign joy2         = joy2_q;
  assign osd_en       = osd_en_q;
  assign osd_wr_valid = osd_wr_valid_q;
  assign osd_wr_addr  = addr_q;
  assign osd_wr_data  = wdata_q;
  assign err_count    = err_q;
  assign busy         = (state_q != S_IDLE);

endmodule
